conv_core_param: RTL

// - Parametrised multi-output-channel KxK convolution core. Generalises the fixed 8-out/3x3 core to OUT_CH kernels x IN_CH input lanes.
// - Adds a self-sequencing weight loader, row-serial window accumulation, a bias/residual select and a sticky protocol-error flag.
// - Sits between the feature line buffers and the output/requantise stage, in the DSP_clk domain.

---
 rtl/conv_core_param_if.sv | 45 ++++
 rtl/conv_core_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/conv_core_param_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_core_param_if
// Brief    : Weight, feature, offset and result signals of conv_core_param.
// Revision : 1.0
// ============================================================================
interface conv_core_param_if #(
    parameter int FEATURE_WIDTH    = 16,
    parameter int WEIGHT_WIDTH     = 16,
    parameter int KERNEL           = 3,
    parameter int IN_CH            = 16,
    parameter int OUT_CH           = 8,
    parameter int MAC_OUTPUT_WIDTH = 36,
    parameter int BIAS_WIDTH       = 32
);
    logic                                 weight_start;
    logic                                 weight_valid;
    logic [IN_CH*WEIGHT_WIDTH-1:0]        weight;
    logic                                 weights_ready;
    logic                                 pulse;
    logic                                 feat_valid;
    logic [IN_CH*KERNEL*FEATURE_WIDTH-1:0] feature_in;
    logic                                 bias_valid;
    logic [OUT_CH*BIAS_WIDTH-1:0]         bias;
    logic                                 bias_or_adder_feature;
    logic [OUT_CH*MAC_OUTPUT_WIDTH-1:0]   adder_feature;
    logic                                 busy;
    logic                                 out_valid;
    logic [OUT_CH*MAC_OUTPUT_WIDTH-1:0]   feature_out;
    logic                                 err;

    modport master (
        output weight_start, weight_valid, weight, pulse, feat_valid, feature_in,
               bias_valid, bias, bias_or_adder_feature, adder_feature,
        input  weights_ready, busy, out_valid, feature_out, err
    );

    modport slave (
        input  weight_start, weight_valid, weight, pulse, feat_valid, feature_in,
               bias_valid, bias, bias_or_adder_feature, adder_feature,
        output weights_ready, busy, out_valid, feature_out, err
    );
endinterface
`default_nettype wire

// File: rtl/conv_core_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_core_param
// Brief    : OUT_CH x IN_CH KxK row-serial convolution core, 4-cycle latency.
//            Define CONV_CORE_SAT_EN to saturate instead of wrap.
// Revision : 1.0
// ============================================================================
module conv_core_param #(
    parameter int FEATURE_WIDTH    = 16,
    parameter int WEIGHT_WIDTH     = 16,
    parameter int KERNEL           = 3,
    parameter int IN_CH            = 16,
    parameter int OUT_CH           = 8,
    parameter int MAC_OUTPUT_WIDTH = 36,
    parameter int BIAS_WIDTH       = 32
) (
    input  wire             DSP_clk,
    input  wire             rst_n,
    conv_core_param_if.slave bus
);
    localparam int c_taps  = KERNEL * KERNEL;
    localparam int c_lanes = IN_CH * KERNEL;
    localparam int c_pw    = FEATURE_WIDTH + WEIGHT_WIDTH;
    localparam int c_sw    = c_pw + $clog2(c_lanes) + 1;
    localparam int c_xw    = ((c_sw > MAC_OUTPUT_WIDTH) ? c_sw : MAC_OUTPUT_WIDTH) + 1;
    localparam int c_tap_w = (c_taps > 1) ? $clog2(c_taps) : 1;
    localparam int c_ch_w  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int c_row_w = (KERNEL > 1) ? $clog2(KERNEL) : 1;
    localparam logic [c_tap_w-1:0] c_last_tap = c_tap_w'(c_taps - 1);
    localparam logic [c_ch_w-1:0]  c_last_ch  = c_ch_w'(OUT_CH - 1);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(KERNEL - 1);
`ifdef CONV_CORE_SAT_EN
    localparam logic signed [c_xw-1:0] c_mac_max =
        {{(c_xw-MAC_OUTPUT_WIDTH+1){1'b0}}, {(MAC_OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_xw-1:0] c_mac_min =
        {{(c_xw-MAC_OUTPUT_WIDTH+1){1'b1}}, {(MAC_OUTPUT_WIDTH-1){1'b0}}};
`endif

    // Brings a wide signed intermediate into the accumulator format.
    function automatic logic signed [MAC_OUTPUT_WIDTH-1:0] to_mac(input logic signed [c_xw-1:0] v);
`ifdef CONV_CORE_SAT_EN
        if (v > c_mac_max) return c_mac_max[MAC_OUTPUT_WIDTH-1:0];
        if (v < c_mac_min) return c_mac_min[MAC_OUTPUT_WIDTH-1:0];
`endif
        return v[MAC_OUTPUT_WIDTH-1:0];
    endfunction

    logic signed [WEIGHT_WIDTH-1:0]     r_w     [OUT_CH][c_taps][IN_CH];
    logic signed [BIAS_WIDTH-1:0]       r_bias  [OUT_CH];
    logic signed [c_pw-1:0]             r_prod  [OUT_CH][c_lanes];
    logic signed [c_sw-1:0]             w_sum   [OUT_CH];
    logic signed [MAC_OUTPUT_WIDTH-1:0] r_sum   [OUT_CH];
    logic signed [MAC_OUTPUT_WIDTH-1:0] r_acc   [OUT_CH];
    logic signed [MAC_OUTPUT_WIDTH-1:0] r_off1  [OUT_CH];
    logic signed [MAC_OUTPUT_WIDTH-1:0] r_off2  [OUT_CH];
    logic signed [MAC_OUTPUT_WIDTH-1:0] r_off3  [OUT_CH];
    logic [OUT_CH*MAC_OUTPUT_WIDTH-1:0] r_fout;
    logic [c_ch_w-1:0]                  r_ld_ch, w_ld_ch;
    logic [c_tap_w-1:0]                 r_ld_tap, w_ld_tap, w_tap_base;
    logic [c_row_w-1:0]                 r_row, w_row;
    logic r_ready, r_err, r_out_vld;
    logic r_s1_vld, r_s1_first, r_s1_last;
    logic r_s2_vld, r_s2_first, r_s2_last, r_s3_done;
    logic w_busy, w_wr_en, w_restart;

    assign w_busy     = (r_row != '0) | r_s1_vld | r_s2_vld | r_s3_done;
    assign w_wr_en    = bus.weight_valid & ~w_busy;
    assign w_ld_ch    = bus.weight_start ? '0 : r_ld_ch;
    assign w_ld_tap   = bus.weight_start ? '0 : r_ld_tap;
    // A pulse mid-window drops the partial rows; this beat becomes row 0.
    assign w_restart  = bus.feat_valid & bus.pulse & (r_row != '0);
    assign w_row      = w_restart ? '0 : r_row;
    assign w_tap_base = c_tap_w'(w_row) * c_tap_w'(KERNEL);

    assign bus.weights_ready = r_ready;
    assign bus.busy          = w_busy;
    assign bus.out_valid     = r_out_vld;
    assign bus.feature_out   = r_fout;
    assign bus.err           = r_err;

    always_comb begin
        for (int o = 0; o < OUT_CH; o++) begin
            w_sum[o] = '0;
            for (int l = 0; l < c_lanes; l++)
                w_sum[o] = w_sum[o] + c_sw'(r_prod[o][l]);
        end
    end

    // Datapath stages advance every cycle; the valid tags decide what is used.
    always_ff @(posedge DSP_clk) begin
        for (int o = 0; o < OUT_CH; o++) begin
            for (int j = 0; j < IN_CH; j++)
                for (int c = 0; c < KERNEL; c++)
                    r_prod[o][j*KERNEL+c] <=
                        c_pw'($signed(bus.feature_in[(j*KERNEL+c)*FEATURE_WIDTH +: FEATURE_WIDTH]))
                        * c_pw'(r_w[o][w_tap_base + c_tap_w'(c)][j]);
            r_off1[o] <= bus.bias_or_adder_feature
                       ? $signed(bus.adder_feature[o*MAC_OUTPUT_WIDTH +: MAC_OUTPUT_WIDTH])
                       : MAC_OUTPUT_WIDTH'(r_bias[o]);
            r_sum[o]  <= to_mac(c_xw'(w_sum[o]));
            r_off2[o] <= r_off1[o];
            r_off3[o] <= r_off2[o];
        end
    end

    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < OUT_CH; o++) begin
                for (int t = 0; t < c_taps; t++)
                    for (int j = 0; j < IN_CH; j++)
                        r_w[o][t][j] <= '0;
                r_bias[o] <= '0;
                r_acc[o]  <= '0;
            end
            r_ld_ch    <= '0;
            r_ld_tap   <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_row      <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s3_done  <= 1'b0;
            r_out_vld  <= 1'b0;
            r_fout     <= '0;
        end else begin
            if (w_wr_en) begin
                for (int j = 0; j < IN_CH; j++)
                    r_w[w_ld_ch][w_ld_tap][j] <= $signed(bus.weight[j*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
                if (w_ld_tap == c_last_tap) begin
                    r_ld_tap <= '0;
                    r_ld_ch  <= (w_ld_ch == c_last_ch) ? '0 : w_ld_ch + c_ch_w'(1);
                end else begin
                    r_ld_tap <= w_ld_tap + c_tap_w'(1);
                    r_ld_ch  <= w_ld_ch;
                end
            end else if (bus.weight_start) begin
                r_ld_ch  <= '0;
                r_ld_tap <= '0;
            end

            if (w_wr_en && w_ld_tap == c_last_tap && w_ld_ch == c_last_ch)
                r_ready <= 1'b1;
            else if (bus.weight_start)
                r_ready <= 1'b0;

            if (bus.bias_valid)
                for (int o = 0; o < OUT_CH; o++)
                    r_bias[o] <= $signed(bus.bias[o*BIAS_WIDTH +: BIAS_WIDTH]);

            if (bus.feat_valid)
                r_row <= (w_row == c_last_row) ? '0 : w_row + c_row_w'(1);

            r_err <= r_err | w_restart | (bus.weight_valid & w_busy);

            r_s1_vld   <= bus.feat_valid;
            r_s1_first <= (w_row == '0);
            r_s1_last  <= (w_row == c_last_row);
            r_s2_vld   <= r_s1_vld;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s3_done  <= r_s2_vld & r_s2_last;

            if (r_s2_vld)
                for (int o = 0; o < OUT_CH; o++)
                    r_acc[o] <= r_s2_first ? r_sum[o]
                                           : to_mac(c_xw'(r_acc[o]) + c_xw'(r_sum[o]));

            r_out_vld <= r_s3_done;
            if (r_s3_done)
                for (int o = 0; o < OUT_CH; o++)
                    r_fout[o*MAC_OUTPUT_WIDTH +: MAC_OUTPUT_WIDTH] <=
                        to_mac(c_xw'(r_acc[o]) + c_xw'(r_off3[o]));
        end
    end
endmodule
`default_nettype wire
